// File: rtl/fp_sub_seq.sv
// Sequential IEEE-754 single-precision subtractor: Diff = A - B.
// The datapath handles one bit per cycle in ALIGN and NORM. Bits shifted out
// during alignment are dropped, so the result is truncated, not rounded.
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Diff,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sign_l_q, sign_l_d, sign_s_q, sign_s_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] sig_l_q, sig_l_d, sig_s_q, sig_s_d;
    logic [24:0] sum_q, sum_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] diff_q, diff_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;

    // Operand decode used by UNPACK. Exponent field 0 is a denormal: the
    // hidden bit is 0 and the effective exponent is 1.
    logic [7:0]  exp_a_f, exp_b_f, eff_a, eff_b, gap;
    logic [23:0] sig_a, sig_b;
    logic        a_big;
    logic [4:0]  shift_amt;

    always_comb begin
        exp_a_f   = a_q[30:23];
        exp_b_f   = b_q[30:23];
        sig_a     = {|exp_a_f, a_q[22:0]};
        sig_b     = {|exp_b_f, b_q[22:0]};
        eff_a     = (exp_a_f == 8'd0) ? 8'd1 : exp_a_f;
        eff_b     = (exp_b_f == 8'd0) ? 8'd1 : exp_b_f;
        a_big     = {eff_a, sig_a} >= {eff_b, sig_b};
        gap       = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
        // Beyond 25 shifts the 24-bit significand is already all zeros.
        shift_amt = (gap > 8'd25) ? 5'd25 : gap[4:0];
    end

    // Next-state and datapath logic for the whole operation sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_l_d = sign_l_q;
        sign_s_d = sign_s_q;
        exp_d    = exp_q;
        sig_l_d  = sig_l_q;
        sig_s_d  = sig_s_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end

            S_UNPACK: begin
                if (exp_a_f == 8'hFF || exp_b_f == 8'hFF) begin
                    diff_d  = 32'h7FC0_0000;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // Subtraction is done as addition of -B.
                    if (a_big) begin
                        sign_l_d = a_q[31];
                        sign_s_d = ~b_q[31];
                        exp_d    = eff_a;
                        sig_l_d  = sig_a;
                        sig_s_d  = sig_b;
                    end else begin
                        sign_l_d = ~b_q[31];
                        sign_s_d = a_q[31];
                        exp_d    = eff_b;
                        sig_l_d  = sig_b;
                        sig_s_d  = sig_a;
                    end
                    cnt_d   = shift_amt;
                    state_d = (shift_amt == 5'd0) ? S_ADD : S_ALIGN;
                end
            end

            S_ALIGN: begin
                sig_s_d = sig_s_q >> 1;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                if (sign_l_q == sign_s_q) begin
                    sum_d = {1'b0, sig_l_q} + {1'b0, sig_s_q};
                end else begin
                    sum_d = {1'b0, sig_l_q} - {1'b0, sig_s_q};
                end
                state_d = S_NORM;
            end

            S_NORM: begin
                if (sum_q == 25'd0) begin
                    diff_d  = 32'h0000_0000;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (sum_q[24]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_q + 8'd1;
                end else if (!sum_q[23] && exp_q > 8'd1) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                    if (exp_q == 8'hFF) begin
                        diff_d = {sign_l_q, 8'hFF, 23'd0};
                        ovf_d  = 1'b1;
                        unf_d  = 1'b0;
                    end else if (!sum_q[23]) begin
                        diff_d = {sign_l_q, 8'd0, sum_q[22:0]};
                        ovf_d  = 1'b0;
                        unf_d  = 1'b1;
                    end else begin
                        diff_d = {sign_l_q, exp_q, sum_q[22:0]};
                        ovf_d  = 1'b0;
                        unf_d  = 1'b0;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_l_q <= 1'b0;
            sign_s_q <= 1'b0;
            exp_q    <= '0;
            sig_l_q  <= '0;
            sig_s_q  <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_l_q <= sign_l_d;
            sign_s_q <= sign_s_d;
            exp_q    <= exp_d;
            sig_l_q  <= sig_l_d;
            sig_s_q  <= sig_s_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign Diff      = diff_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: request to compute A - B, sampled only in IDLE.
REQ-004 The module SHALL have ports A and B, inputs, 32 bits each: IEEE-754 single-precision minuend and subtrahend.
REQ-005 The module SHALL have port Diff, output, 32 bits: IEEE-754 single-precision result A - B.
REQ-006 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 The module SHALL have port done, output, 1 bit: one-cycle pulse marking Diff and the flags as valid.
REQ-008 The module SHALL have ports overflow and underflow, outputs, 1 bit each: result status flags.

Function
REQ-009 The module SHALL sequence through states IDLE, UNPACK, ALIGN, ADD, NORM and DONE.
REQ-010 In IDLE with start=1, the module SHALL latch A and B, go to UNPACK and set busy=1 on the same edge.
REQ-011 The module SHALL ignore start in every state other than IDLE.
REQ-012 In UNPACK, the module SHALL invert the sign of B.
REQ-013 In UNPACK, the module SHALL form each 24-bit significand with hidden bit 1 for exponent field 1..254, and hidden bit 0 with effective exponent 1 for exponent field 0 (denormal).
REQ-014 In UNPACK, the module SHALL swap the operands so the larger-magnitude operand is first, then go to ALIGN.
REQ-015 If either exponent field is 255, UNPACK SHALL instead set Diff=32'h7FC00000 with overflow=0 and underflow=0, and go directly to DONE.
REQ-016 ALIGN SHALL right-shift the smaller significand one bit per cycle, discarding shifted-out bits (truncation).
REQ-017 ALIGN SHALL shift min(exponent difference, 25) times and SHALL take 0 cycles when the exponents are equal.
REQ-018 ADD SHALL take one cycle: add significands when the effective signs match, otherwise subtract the smaller from the larger; the result is 25 bits including carry, and the sign is that of the larger operand.
REQ-019 In NORM, on a carry-out, the module SHALL shift right 1 and increment the exponent in one cycle.
REQ-020 Otherwise, NORM SHALL shift left one bit per cycle, decrementing the exponent, until bit 23 is 1 or the exponent reaches 1.
REQ-021 An exact zero difference SHALL produce +0 (32'h00000000), with both flags 0.
REQ-022 If the exponent reaches 255 after normalization, the module SHALL set Diff to signed infinity (exponent 255, mantissa 0) and overflow=1.
REQ-023 If the normalized result is nonzero with bit 23 = 0 at exponent 1, the module SHALL encode it as a denormal (exponent field 0) and set underflow=1.
REQ-024 In DONE, the module SHALL drive done=1 for exactly one cycle, drop busy to 0 on the next edge and return to IDLE.
REQ-025 Diff, overflow and underflow SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-026 Worst-case latency from start to done SHALL be no more than 55 cycles.

Reset
REQ-027 While rst_n=0, regardless of clk, the module SHALL force the state to IDLE, Diff=0, busy=0, done=0, overflow=0 and underflow=0.
REQ-028 Deasserting reset mid-operation SHALL abandon the operation with no done pulse.
REQ-029 The first start after reset SHALL be accepted in the first cycle after rst_n rises.

Verification
REQ-030 The bench SHALL apply A=3F800000, B=3F000000 and start, and SHALL check for Diff=3F000000, flags 0, done pulse one cycle wide.
REQ-031 The bench SHALL apply A=BE800000, B=3E000000 and SHALL check for Diff=BEC00000.
REQ-032 The bench SHALL apply A=40A00000, B=40A00000 and SHALL check for Diff=00000000, with zero ALIGN cycles.
REQ-033 The bench SHALL apply A=7F7FFFFF, B=FF7FFFFF and SHALL check for Diff=7F800000, overflow=1.
REQ-034 The bench SHALL apply A=00000002, B=00000001 and SHALL check for Diff=00000001, underflow=1.
REQ-035 The bench SHALL pulse rst_n low during ALIGN of A=4B000000, B=3F800000 and SHALL check that busy, done and Diff are immediately 0 and that no done pulse follows; it SHALL then check that a second start is honoured while start during busy is ignored.
